// File: rtl/inference_sequencer.sv
// Per-sample control sequencer for an N-layer conv1d pipeline: input shift strobe,
// per-layer reset/wait with watchdog, activation-cache strobes, overrun tracking, latency capture.
module inference_sequencer #(
  parameter int N_LAYERS           = 4,
  parameter int TIMEOUT            = 1024,
  parameter int CNT_W              = 16,
  parameter int OVR_W              = 8,
  parameter int RESTART_ON_OVERRUN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_clk,
  input  logic [N_LAYERS-1:0]         layer_out_v,
  input  logic                        clear_flags,
  output logic                        shift_strobe,
  output logic [N_LAYERS-1:0]         layer_rst,
  output logic [N_LAYERS-2:0]         cache_strobe,
  output logic [$clog2(N_LAYERS)-1:0] layer_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_flag,
  output logic                        overrun_flag,
  output logic [OVR_W-1:0]            overrun_count,
  output logic [CNT_W-1:0]            last_latency
);

  localparam int IDX_W  = $clog2(N_LAYERS);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_LAYERS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_LRST  = 3'd2;
  localparam logic [2:0] S_LRUN  = 3'd3;
  localparam logic [2:0] S_CACHE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state, state_nxt;
  logic              prev_sample_clk;
  logic              sample_edge;
  logic              overrun;
  logic              timeout_hit;
  logic              cur_out_v;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  lat_cnt;
  logic [CNT_W-1:0]  lat_cur;

  assign sample_edge = sample_clk & ~prev_sample_clk;
  // An edge landing in DONE starts the next sample rather than counting as an overrun.
  assign overrun     = sample_edge && (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    cur_out_v = 1'b0;
    for (int unsigned i = 0; i < N_LAYERS; i++)
      if (layer_idx == IDX_W'(i)) cur_out_v = layer_out_v[i];
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:  if (sample_edge) state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_LRST;
      S_LRST:  state_nxt = S_LRUN;
      S_LRUN: begin
        if (cur_out_v) begin
          state_nxt = (layer_idx == LAST_IDX) ? S_DONE : S_CACHE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_CACHE: state_nxt = S_LRST;
      S_DONE:  state_nxt = sample_edge ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A restarting overrun pre-empts whatever the current state would have done.
    if (overrun && (RESTART_ON_OVERRUN != 0)) begin
      state_nxt   = S_SHIFT;
      timeout_hit = 1'b0;
    end
  end

  // Busy-cycle count including the current cycle; SHIFT always restarts it at 1.
  assign lat_cur = (state == S_SHIFT) ? CNT_W'(1)
                 : ((&lat_cnt) ? lat_cnt : lat_cnt + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      prev_sample_clk <= 1'b0;
      layer_idx       <= '0;
      wait_cnt        <= '0;
      lat_cnt         <= '0;
      last_latency    <= '0;
      timeout_flag    <= 1'b0;
      overrun_flag    <= 1'b0;
      overrun_count   <= '0;
    end else begin
      prev_sample_clk <= sample_clk;
      state           <= state_nxt;

      if (state_nxt == S_SHIFT)  layer_idx <= '0;
      else if (state == S_CACHE) layer_idx <= layer_idx + IDX_W'(1);

      if (state == S_LRST)      wait_cnt <= '0;
      else if (state == S_LRUN) wait_cnt <= wait_cnt + WAIT_W'(1);

      if (state != S_IDLE) lat_cnt      <= lat_cur;
      if (state == S_DONE) last_latency <= lat_cur;

      if (timeout_hit)      timeout_flag <= 1'b1;
      else if (clear_flags) timeout_flag <= 1'b0;

      if (overrun) begin
        overrun_flag  <= 1'b1;
        overrun_count <= clear_flags ? OVR_W'(1)
                       : ((&overrun_count) ? overrun_count : overrun_count + OVR_W'(1));
      end else if (clear_flags) begin
        overrun_flag  <= 1'b0;
        overrun_count <= '0;
      end
    end
  end

  always_comb begin
    shift_strobe = (state == S_SHIFT);
    done         = (state == S_DONE);
    busy         = (state != S_IDLE);
    layer_rst    = '0;
    cache_strobe = '0;
    for (int unsigned i = 0; i < N_LAYERS; i++)
      layer_rst[i] = (state == S_LRST) && (layer_idx == IDX_W'(i));
    for (int unsigned i = 0; i < N_LAYERS - 1; i++)
      cache_strobe[i] = (state == S_CACHE) && (layer_idx == IDX_W'(i));
  end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
Parametrised control sequencer that runs an N-layer conv1d pipeline once per audio sample. It detects the rising edge of sample_clk, strobes the input left-shift buffers, then resets and waits on each conv layer in turn, clocking the activation cache between layers. Compared with the fixed two-layer network state machine, it adds configurable depth, a per-layer watchdog timeout, overrun detection and counting, a restart/ignore mode, and latency measurement. It sits between the codec sample clock and the conv1d/activation_cache instances inside the network top.

Parameters:
N_LAYERS, 4, number of conv layers sequenced; must be >= 2.
TIMEOUT, 1024, maximum cycles spent in LRUN for one layer before abort; must be >= 1.
CNT_W, 16, width of last_latency; saturates at all-ones.
OVR_W, 8, width of overrun_count; saturates at all-ones.
RESTART_ON_OVERRUN, 1, 1: an edge while busy aborts and restarts; 0: the edge is ignored.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
sample_clk  in  1  sample-rate clock, already synchronous to clk.
layer_out_v  in  N_LAYERS  out_v from each conv1d; bit i belongs to layer i.
clear_flags  in  1  one-cycle pulse that clears timeout_flag, overrun_flag and overrun_count.
shift_strobe  out  1  clock pulse to the left-shift buffers.
layer_rst  out  N_LAYERS  one-hot reset pulse to conv layer i.
cache_strobe  out  N_LAYERS-1  clock pulse to the activation cache after layer i.
layer_idx  out  $clog2(N_LAYERS)  index of the layer currently sequenced.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse; the final layer output is valid.
timeout_flag  out  1  sticky; a layer exceeded TIMEOUT.
overrun_flag  out  1  sticky; a sample edge arrived while busy.
overrun_count  out  OVR_W  saturating count of overrun edges.
last_latency  out  CNT_W  busy cycles of the last completed inference.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. On rst: state=IDLE, layer_idx=0, prev_sample_clk=0, and every output is 0.
- Edge detect: edge = sample_clk & ~prev_sample_clk, where prev_sample_clk is registered every cycle.
- States and transitions:
  - IDLE: on edge -> SHIFT.
  - SHIFT: always -> LRST; load layer_idx=0.
  - LRST: always -> LRUN; clear the wait counter.
  - LRUN: if layer_out_v[layer_idx]=1, go to CACHE when layer_idx < N_LAYERS-1, otherwise to DONE. Else if wait counter = TIMEOUT-1, set timeout_flag and go to IDLE with no done. Else increment the wait counter.
  - CACHE: layer_idx++ -> LRST.
  - DONE: -> IDLE, or -> SHIFT if an edge is present in that cycle. An edge in the DONE cycle is a new sample, not an overrun.
- Outputs, Moore-decoded from the state register (glitch-free, one cycle each):
  - shift_strobe = (state==SHIFT).
  - layer_rst[i] = (state==LRST && layer_idx==i).
  - cache_strobe[i] = (state==CACHE && layer_idx==i).
  - done = (state==DONE).
  - busy = (state!=IDLE).
- Timing: with the edge detected in cycle 0 and every out_v high on the first LRUN cycle, SHIFT is in cycle 1 and DONE in cycle 3*N_LAYERS+1. Each extra LRUN wait cycle adds 1.
- Latency count: counts cycles with busy=1 from SHIFT through DONE inclusive, so the minimum is 3*N_LAYERS+1. It is copied to last_latency on DONE and saturates. Aborted runs (timeout, restart) do not update last_latency.
- Overrun: an edge while busy and state!=DONE sets overrun_flag and increments overrun_count (saturating).
  - RESTART_ON_OVERRUN=1: state -> SHIFT next cycle and the latency counter restarts.
  - RESTART_ON_OVERRUN=0: the edge is dropped and sequencing continues.
- Precedence within one cycle:
  - rst beats everything.
  - An overrun edge beats an LRUN transition when RESTART_ON_OVERRUN=1.
  - layer_out_v beats the timeout in the same cycle.
  - A flag set beats clear_flags in the same cycle.
- layer_out_v bits other than layer_idx are ignored.
- layer_out_v is sampled only in LRUN; a stale high in LRST has no effect.
- Reset mid-operation: the next cycle is IDLE with all strobes low. No partial strobe or done is emitted.

Test Plan:
- Nominal: N_LAYERS=4; rising edge at cycle 0; each out_v high 5 cycles after its layer_rst -> shift_strobe at cycle 1; layer_rst[0..3] and cache_strobe[0..2] one cycle each in order; done once; last_latency = 13+4*4 = 29.
- Minimum latency: out_v tied high -> done at cycle 13, last_latency = 13, busy high for cycles 1..13.
- Timeout: TIMEOUT=8; layer 2 out_v never asserts -> 8 cycles in LRUN for layer 2, then IDLE; timeout_flag = 1, no done, last_latency unchanged; clear_flags -> timeout_flag = 0.
- Overrun with restart (RESTART_ON_OVERRUN=1): second edge while in LRUN of layer 1 -> overrun_flag = 1, overrun_count = 1, shift_strobe on the next cycle, layer_idx = 0. Same stimulus with RESTART_ON_OVERRUN=0 -> count increments and the sequence completes normally with one done.
- Boundaries: edge in the DONE cycle -> SHIFT follows, overrun_count unchanged. OVR_W=2 with 5 overruns -> overrun_count = 3.
- Reset mid-run: rst pulsed during CACHE -> all outputs 0 the next cycle, state IDLE; a later edge runs a full clean sequence.
